led_seq_ctrl: RTL and testbench



---
 rtl/led_ctrl_pkg.sv | 44 ++++
 rtl/key_debounce.sv | 55 +++++
 rtl/led_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_led_seq_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_ctrl_pkg
// Description : Mode encoding, per-mode start patterns and key level for the
//               LED sequencer.
// Revision    : 1.0
// ============================================================================
package led_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_FLOW_L   = 2'd0,
      MODE_FLOW_R   = 2'd1,
      MODE_PINGPONG = 2'd2,
      MODE_BLINK    = 2'd3
   } mode_e;

   localparam logic [3:0] c_start_flow_l   = 4'b0001;
   localparam logic [3:0] c_start_flow_r   = 4'b1000;
   localparam logic [3:0] c_start_pingpong = 4'b0001;
   localparam logic [3:0] c_start_blink    = 4'b1111;

   // Board keys pull low when pressed
   localparam logic c_key_active = 1'b0;

   function automatic logic [3:0] start_pattern(input mode_e m);
      case (m)
         MODE_FLOW_L:   return c_start_flow_l;
         MODE_FLOW_R:   return c_start_flow_r;
         MODE_PINGPONG: return c_start_pingpong;
         default:       return c_start_blink;
      endcase
   endfunction

   function automatic mode_e next_mode(input mode_e m);
      case (m)
         MODE_FLOW_L:   return MODE_FLOW_R;
         MODE_FLOW_R:   return MODE_PINGPONG;
         MODE_PINGPONG: return MODE_BLINK;
         default:       return MODE_FLOW_L;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : 2-flop synchroniser, stability counter and one-cycle press
//               pulse for a raw active-low push-button.
// Revision    : 1.0
// ============================================================================
module key_debounce
   import led_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_key_n,
   output logic o_press
);

   localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

   logic               r_sync1;
   logic               r_sync2;
   logic               r_level;
   logic               r_press;
   logic [c_cnt_w-1:0] r_cnt;

   // Any sample matching the accepted level restarts the stability count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= ~c_key_active;
         r_sync2 <= ~c_key_active;
         r_level <= ~c_key_active;
         r_cnt   <= '0;
         r_press <= 1'b0;
      end else begin
         r_sync1 <= i_key_n;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == c_cnt_last) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
            r_press <= (r_sync2 == c_key_active);
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_seq_ctrl
// Description : Selectable, pausable pattern sequencer for the 4-bit LED bank.
//               Define LED_PWM_DIM_EN to add PWM dimming of the LED outputs.
// Revision    : 1.0
// ============================================================================
module led_seq_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int NUM_LED         = 4,
   parameter int TICK_CYCLES     = 50_000_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000
`ifdef LED_PWM_DIM_EN
   ,
   parameter int DIM_DUTY        = 8
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               key_mode_n,
   input  logic               key_pause_n,
   output logic [NUM_LED-1:0] led,
   output logic [1:0]         mode,
   output logic               running
);

   localparam int c_tick_w = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_CYCLES - 1);

   logic                w_mode_press;
   logic                w_pause_press;
   logic                w_tick;
   logic [NUM_LED-1:0]  w_pp_next;
   logic [c_tick_w-1:0] r_tick_cnt;
   mode_e               r_mode;
   logic [NUM_LED-1:0]  r_pattern;
   logic                r_dir_up;
   logic                r_running;

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key_mode (
      .clk     (clk),
      .rst     (rst),
      .i_key_n (key_mode_n),
      .o_press (w_mode_press)
   );

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key_pause (
      .clk     (clk),
      .rst     (rst),
      .i_key_n (key_pause_n),
      .o_press (w_pause_press)
   );

   assign w_tick = (r_tick_cnt == c_tick_last);

   always_comb begin
      w_pp_next = r_dir_up ? {r_pattern[NUM_LED-2:0], 1'b0}
                           : {1'b0, r_pattern[NUM_LED-1:1]};
   end

   // A mode press overrides a coincident tick; pause toggles independently
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mode     <= MODE_FLOW_L;
         r_pattern  <= c_start_flow_l;
         r_dir_up   <= 1'b1;
         r_running  <= 1'b1;
         r_tick_cnt <= '0;
      end else begin
         if (w_pause_press) begin
            r_running <= ~r_running;
         end
         if (w_mode_press) begin
            r_mode     <= next_mode(r_mode);
            r_pattern  <= start_pattern(next_mode(r_mode));
            r_dir_up   <= 1'b1;
            r_tick_cnt <= '0;
         end else if (r_running) begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_tick) begin
               case (r_mode)
                  MODE_FLOW_L: r_pattern <= {r_pattern[NUM_LED-2:0], r_pattern[NUM_LED-1]};
                  MODE_FLOW_R: r_pattern <= {r_pattern[0], r_pattern[NUM_LED-1:1]};
                  MODE_PINGPONG: begin
                     // Turn around on reaching an end so it shows only once
                     r_pattern <= w_pp_next;
                     if (w_pp_next[NUM_LED-1]) begin
                        r_dir_up <= 1'b0;
                     end else if (w_pp_next[0]) begin
                        r_dir_up <= 1'b1;
                     end
                  end
                  default: r_pattern <= ~r_pattern;
               endcase
            end
         end
      end
   end

   assign mode    = r_mode;
   assign running = r_running;

`ifdef LED_PWM_DIM_EN
   logic [3:0] r_pwm_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pwm_cnt <= 4'd0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 4'd1;
      end
   end

   assign led = r_pattern & {NUM_LED{(int'({28'd0, r_pwm_cnt}) < DIM_DUTY)}};
`else
   assign led = r_pattern;
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_seq_ctrl
// Description : Self-checking bench for led_seq_ctrl: directed sequences, a
//               paused-mode vector table and random key activity vs a model.
// Revision    : 1.0
// ============================================================================
module tb_led_seq_ctrl;

   localparam int c_tick = 25;
   localparam int c_deb  = 4;

   typedef struct {
      bit         m;
      bit         p;
      int         e_mode;
      logic [3:0] e_led;
      bit         e_run;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_mode_n = 1'b1;
   logic       key_pause_n = 1'b1;
   logic [3:0] led;
   logic [1:0] mode;
   logic       running;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Reference model: pattern is a position index into each mode's cycle
   int        m_mode, m_pos, m_cnt, m_pwm;
   bit        m_run, m_pend_mode, m_pend_pause, acc_mode, acc_pause;
   bit [15:0] h_mode, h_pause;
   int        pp_seq[6] = '{0, 1, 2, 3, 2, 1};
   int        t1_cyc[5] = '{24, 25, 50, 75, 100};
   int        t1_led[5] = '{1, 2, 4, 8, 1};
   int        pp_exp[9] = '{1, 2, 4, 8, 4, 2, 1, 2, 4};
   vec_t      tbl[7];

   led_seq_ctrl #(
      .NUM_LED        (4),
      .TICK_CYCLES    (c_tick),
      .DEBOUNCE_CYCLES(c_deb)
`ifdef LED_PWM_DIM_EN
      ,
      .DIM_DUTY       (8)
`endif
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_mode_n  (key_mode_n),
      .key_pause_n (key_pause_n),
      .led         (led),
      .mode        (mode),
      .running     (running)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      m_mode = 0; m_pos = 0; m_cnt = 0; m_pwm = 0; m_run = 1'b1;
      m_pend_mode = 1'b0; m_pend_pause = 1'b0;
      acc_mode = 1'b0; acc_pause = 1'b0;
      h_mode = '1; h_pause = '1;
   endfunction

   // acc: 1 = accepted pressed. Flips when the synchronised samples
   // (raw delayed by two edges) have all sat at the other level c_deb times.
   function automatic bit key_step(input bit raw, inout bit [15:0] h, inout bit acc);
      bit stable = 1'b1;
      h = {h[14:0], raw};
      for (int i = 2; i < c_deb + 2; i++) begin
         if (h[i] != acc) stable = 1'b0;
      end
      if (stable) begin
         acc = !acc;
         return acc;
      end
      return 1'b0;
   endfunction

   function automatic void model_edge();
      bit tick    = (m_cnt == c_tick - 1);
      bit old_run = m_run;
      if (m_pend_pause) m_run = !m_run;
      if (m_pend_mode) begin
         m_mode = (m_mode + 1) % 4;
         m_pos  = 0;
         m_cnt  = 0;
      end else if (old_run) begin
         if (tick) begin
            m_pos = (m_pos + 1) % 12;
            m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end
      m_pend_mode  = key_step(key_mode_n, h_mode, acc_mode);
      m_pend_pause = key_step(key_pause_n, h_pause, acc_pause);
      m_pwm = (m_pwm + 1) % 16;
   endfunction

   function automatic logic [3:0] model_led();
      logic [3:0] p;
      case (m_mode)
         0:       p = 4'b0001 << (m_pos % 4);
         1:       p = 4'b1000 >> (m_pos % 4);
         2:       p = 4'b0001 << pp_seq[m_pos % 6];
         default: p = ((m_pos % 2) == 1) ? 4'b0000 : 4'b1111;
      endcase
`ifdef LED_PWM_DIM_EN
      if (m_pwm >= 8) p = 4'b0000;
`endif
      return p;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      cyc++;
      n_checks++;
      if (led !== model_led() || mode !== 2'(m_mode) || running !== m_run) begin
         n_errors++;
         $display("FAIL model cyc %0d: led=%b exp %b mode=%0d exp %0d running=%b exp %b",
                  cyc, led, model_led(), mode, m_mode, running, m_run);
      end
   endtask

   task automatic do_reset();
      key_mode_n  = 1'b1;
      key_pause_n = 1'b1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      chk("reset_led", int'(led), 1);
      chk("reset_mode", int'(mode), 0);
      chk("reset_running", int'(running), 1);
   endtask

   task automatic press_key(input bit pm, input bit pp, output int c_evt);
      logic [1:0] m0 = mode;
      logic       r0 = running;
      c_evt = -1;
      key_mode_n  = !pm;
      key_pause_n = !pp;
      for (int i = 0; i < 16; i++) begin
         if (i == 8) begin
            key_mode_n  = 1'b1;
            key_pause_n = 1'b1;
         end
         step();
         if (c_evt < 0 && (mode != m0 || running != r0)) c_evt = cyc;
      end
      chk("press_event_seen", int'(c_evt >= 0), 1);
   endtask

   task automatic wait_led(input string name, input logic [3:0] target, input int bound,
                           output int c);
      c = -1;
      for (int i = 0; i < bound && c < 0; i++) begin
         step();
         if (led == target) c = cyc;
      end
      chk(name, int'(c >= 0), 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      n_errors++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, c1, cT, cP, cR, cS, n_chg, seq_n, on_cnt;
      logic [1:0] prev;
      logic [3:0] last;

      tbl[0] = '{1'b0, 1'b1, 0, 4'b0001, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 1, 4'b1000, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 2, 4'b0001, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 3, 4'b1111, 1'b0};
      tbl[4] = '{1'b1, 1'b1, 0, 4'b0001, 1'b1};
      tbl[5] = '{1'b0, 1'b1, 0, 4'b0001, 1'b0};
      tbl[6] = '{1'b1, 1'b1, 1, 4'b1000, 1'b1};

      do_reset();

`ifndef LED_PWM_DIM_EN
      // Free-running FLOW_L after reset
      for (int n = 1; n <= 100; n++) begin
         step();
         for (int j = 0; j < 5; j++) begin
            if (n == t1_cyc[j]) chk("flow_l_step", int'(led), t1_led[j]);
         end
      end
      chk("flow_l_mode", int'(mode), 0);
      chk("flow_l_running", int'(running), 1);

      // Short glitches are rejected, a clean press gives exactly one change
      for (int g = 0; g < 2; g++) begin
         key_mode_n = 1'b0;
         repeat (3) step();
         key_mode_n = 1'b1;
         repeat (6) step();
      end
      chk("glitch_no_change", int'(mode), 0);
      c0 = -1; n_chg = 0; prev = mode;
      key_mode_n = 1'b0;
      for (int i = 0; i < 24; i++) begin
         if (i == 10) key_mode_n = 1'b1;
         step();
         if (mode != prev) begin
            n_chg++;
            prev = mode;
            if (c0 < 0) begin
               c0 = cyc;
               chk("flow_r_start", int'(led), 8);
            end
         end
      end
      chk("one_mode_event", n_chg, 1);
      chk("mode_flow_r", int'(mode), 1);
      wait_led("flow_r_step_seen", 4'b0100, 40, c1);
      chk("flow_r_step_gap", c1 - c0, 25);

      // PINGPONG over 8 ticks
      press_key(1'b1, 1'b0, c0);
      chk("mode_pingpong", int'(mode), 2);
      seq_n = 1; last = led;
      chk("pp_seq_first", int'(led), pp_exp[0]);
      for (int i = 0; i < 8 * c_tick + 10 && seq_n < 9; i++) begin
         step();
         if (led != last) begin
            last = led;
            chk("pp_seq", int'(led), pp_exp[seq_n]);
            seq_n++;
         end
      end
      chk("pp_seq_len", seq_n, 9);

      // Pause in FLOW_L at 0100 and resume with the held counter
      press_key(1'b1, 1'b0, c0);
      press_key(1'b1, 1'b0, c0);
      chk("mode_back_flow_l", int'(mode), 0);
      wait_led("flow_l_0100_seen", 4'b0100, 80, cT);
      repeat (3) step();
      press_key(1'b0, 1'b1, cP);
      chk("paused", int'(running), 0);
      repeat (100) step();
      chk("paused_led_hold", int'(led), 4);
      chk("paused_still", int'(running), 0);
      press_key(1'b0, 1'b1, cR);
      chk("resumed", int'(running), 1);
      wait_led("resume_step_seen", 4'b1000, 40, cS);
      chk("resume_total_cycles", (cP - cT) + (cS - cR), 25);
      chk("resume_not_full", int'((cS - cR) < 25), 1);

      // Mode press landing on the tick edge: start pattern, no extra step
      wait_led("flow_l_wrap_seen", 4'b0001, 40, cT);
      repeat (18) step();
      key_mode_n = 1'b0;
      repeat (6) step();
      chk("collide_before_mode", int'(mode), 0);
      chk("collide_before_led", int'(led), 1);
      step();
      key_mode_n = 1'b1;
      chk("collide_mode", int'(mode), 1);
      chk("collide_led", int'(led), 8);
      while (cyc < cT + 49) step();
      chk("collide_hold", int'(led), 8);
      step();
      chk("collide_next_step", int'(led), 4);

      // Paused mode/pause vector table
      do_reset();
      for (int r = 0; r < 7; r++) begin
         press_key(tbl[r].m, tbl[r].p, c0);
         chk("tbl_mode", int'(mode), tbl[r].e_mode);
         chk("tbl_led", int'(led), int'(tbl[r].e_led));
         chk("tbl_running", int'(running), int'(tbl[r].e_run));
      end

      // Asynchronous reset mid-BLINK
      press_key(1'b1, 1'b0, c0);
      press_key(1'b1, 1'b0, c0);
      chk("mode_blink", int'(mode), 3);
      repeat (5) step();
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_led", int'(led), 1);
      chk("async_rst_mode", int'(mode), 0);
      chk("async_rst_running", int'(running), 1);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (5) step();
`else
      on_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         if (led != 4'b0000) on_cnt++;
      end
      chk("pwm_duty_on_cycles", on_cnt, 8);
`endif

      // Random key activity against the model
      do_reset();
      for (int it = 0; it < 300; it++) begin
         key_mode_n  = ($urandom_range(0, 3) != 0);
         key_pause_n = ($urandom_range(0, 3) != 0);
         repeat ($urandom_range(1, 14)) step();
      end
      key_mode_n  = 1'b1;
      key_pause_n = 1'b1;
      repeat (20) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
